hazard_ctrl_unit: RTL and testbench

//  Parametrised forwarding and stall controller for the 5-stage MIPS pipeline (IF/ID/EXE/MEM/WB).
//  - Forwarding: selects EXE-stage operand sources.
//  - Load-use detection: performed in ID, with a multi-cycle load stall counter.
//  - Multi-cycle multiply: tracks EXE occupancy.
//  - Branch flush: kills wrong-path instructions on a taken branch.
//  - Drives the hold/flush controls of the PC and the IF/ID, ID/EXE and EXE/MEM registers.

---
 rtl/hazard_ctrl_unit.sv | 196 +++++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_unit
// Description : Forwarding and stall controller for a 5-stage MIPS pipeline
//               (IF/ID/EXE/MEM/WB). Selects EXE operand sources, detects
//               load-use hazards in ID (multi-cycle stall counter), tracks
//               multi-cycle multiply occupancy of EXE, flushes wrong-path
//               instructions on a taken branch, and drives the hold/flush
//               controls of the PC and the IF/ID, ID/EXE and EXE/MEM registers.
// Optional    : `define HAZ_STALL_CNT_EN adds parameter CNT_W and output
//               Stall_Cycles (saturating count of cycles with PC_Hold=1).
// Ports       :
//   clk, rst_n                        clock (rising edge), async reset (low)
//   ID_Rs, ID_Rt, ID_UseRt            source registers of the ID instruction
//   EXE_Rs, EXE_Rt, EXE_UseRt         source registers of the EXE instruction
//   EXE_Rw, EXE_RegWr, EXE_MemtoReg   destination / load info of EXE
//   EXE_MulStart                      pulse: a multiply entered EXE
//   Branch_Taken                      branch resolved taken in EXE
//   MEM_Rw, MEM_RegWr, MEM_MemtoReg   destination / load info of MEM
//   WB_Rw, WB_RegWr                   destination info of WB
//   FwdA, FwdB                        00 MEM_Result, 01 WB_BusW, 10 register
//   PC_Hold, IFID_Hold, IFID_Flush    pipeline front-end controls
//   IDEX_Hold, IDEX_Flush             ID/EXE register controls
//   EXMEM_Flush                       bubble into EXE/MEM
//   Mul_Busy                          multiply occupies EXE
//   Stall_Cycles (optional)           saturating PC_Hold cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 4
`ifdef HAZ_STALL_CNT_EN
  , parameter int CNT_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ID_Rs,
  input  logic [REG_AW-1:0] ID_Rt,
  input  logic              ID_UseRt,
  input  logic [REG_AW-1:0] EXE_Rs,
  input  logic [REG_AW-1:0] EXE_Rt,
  input  logic              EXE_UseRt,
  input  logic [REG_AW-1:0] EXE_Rw,
  input  logic              EXE_RegWr,
  input  logic              EXE_MemtoReg,
  input  logic              EXE_MulStart,
  input  logic              Branch_Taken,
  input  logic [REG_AW-1:0] MEM_Rw,
  input  logic              MEM_RegWr,
  input  logic              MEM_MemtoReg,
  input  logic [REG_AW-1:0] WB_Rw,
  input  logic              WB_RegWr,
  output logic [1:0]        FwdA,
  output logic [1:0]        FwdB,
  output logic              PC_Hold,
  output logic              IFID_Hold,
  output logic              IFID_Flush,
  output logic              IDEX_Hold,
  output logic              IDEX_Flush,
  output logic              EXMEM_Flush,
  output logic              Mul_Busy
`ifdef HAZ_STALL_CNT_EN
  , output logic [CNT_W-1:0] Stall_Cycles
`endif
);

  // Counter widths wide enough to hold LAT-1 (minimum one bit).
  localparam int LCW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam int MCW = (MUL_LAT  > 1) ? $clog2(MUL_LAT)  : 1;

  localparam logic [1:0] FWD_MEM = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_REG = 2'b10;

  logic [LCW-1:0] load_cnt_q, load_cnt_d;
  logic [MCW-1:0] mul_cnt_q,  mul_cnt_d;
  logic           mul_busy;
  logic           luh;
  logic           ld_stall;

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  always_comb begin
    mul_busy = (mul_cnt_q != '0);
    luh      = EXE_MemtoReg && EXE_RegWr && (EXE_Rw != '0) &&
               ((ID_Rs == EXE_Rw) || (ID_UseRt && (ID_Rt == EXE_Rw)));
    // The hazard cycle itself stalls even before the counter is armed.
    ld_stall = luh || (load_cnt_q != '0);
  end

  // --------------------------------------------------------------------------
  // Counter next-state
  // --------------------------------------------------------------------------
  always_comb begin
    mul_cnt_d = '0;
    if (mul_busy) begin
      // A start pulse while busy is ignored: keep counting down.
      mul_cnt_d = mul_cnt_q - MCW'(1);
    end else if (EXE_MulStart) begin
      mul_cnt_d = MCW'(MUL_LAT - 1);
    end
  end

  always_comb begin
    load_cnt_d = load_cnt_q;
    // The load stall is frozen while the multiply owns EXE, so it resumes
    // afterwards with whatever count it had left.
    if (!mul_busy) begin
      if (Branch_Taken) begin
        load_cnt_d = '0;
      end else if (load_cnt_q != '0) begin
        load_cnt_d = load_cnt_q - LCW'(1);
      end else if (luh) begin
        load_cnt_d = LCW'(LOAD_LAT - 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_q <= '0;
      mul_cnt_q  <= '0;
    end else begin
      load_cnt_q <= load_cnt_d;
      mul_cnt_q  <= mul_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Everything is forced to its idle value while rst_n is low so the
  // controls drop immediately, independent of the current inputs.
  // --------------------------------------------------------------------------
  always_comb begin
    FwdA        = FWD_REG;
    FwdB        = FWD_REG;
    PC_Hold     = 1'b0;
    IFID_Hold   = 1'b0;
    IFID_Flush  = 1'b0;
    IDEX_Hold   = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    Mul_Busy    = 1'b0;

    if (rst_n) begin
      // Register 0 never forwards: a zero source is rejected up front.
      if (EXE_Rs != '0) begin
        if (MEM_RegWr && !MEM_MemtoReg && (MEM_Rw == EXE_Rs)) begin
          FwdA = FWD_MEM;
        end else if (WB_RegWr && (WB_Rw == EXE_Rs)) begin
          FwdA = FWD_WB;
        end
      end
      if (EXE_UseRt && (EXE_Rt != '0)) begin
        if (MEM_RegWr && !MEM_MemtoReg && (MEM_Rw == EXE_Rt)) begin
          FwdB = FWD_MEM;
        end else if (WB_RegWr && (WB_Rw == EXE_Rt)) begin
          FwdB = FWD_WB;
        end
      end

      Mul_Busy = mul_busy;
      if (mul_busy) begin
        PC_Hold     = 1'b1;
        IFID_Hold   = 1'b1;
        IDEX_Hold   = 1'b1;
        EXMEM_Flush = 1'b1;
      end else if (Branch_Taken) begin
        IFID_Flush  = 1'b1;
        IDEX_Flush  = 1'b1;
      end else if (ld_stall) begin
        PC_Hold     = 1'b1;
        IFID_Hold   = 1'b1;
        IDEX_Flush  = 1'b1;
      end
    end
  end

`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (PC_Hold && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign Stall_Cycles = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl_unit
// Description : Self-checking bench for hazard_ctrl_unit (LOAD_LAT=3,
//               MUL_LAT=4). Table-driven forwarding vectors, directed
//               multi-cycle sequences and randomized stimulus against a
//               behavioural reference model. Define HAZ_STALL_CNT_EN to also
//               exercise the stall counter with CNT_W=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_unit;

  localparam int REG_AW   = 5;
  localparam int LOAD_LAT = 3;
  localparam int MUL_LAT  = 4;
  localparam int CNT_W    = 4;

  // Control vector: {PC_Hold, IFID_Hold, IFID_Flush, IDEX_Hold, IDEX_Flush,
  //                  EXMEM_Flush, Mul_Busy}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LD   = 7'b1100100;
  localparam logic [6:0] C_MUL  = 7'b1101011;
  localparam logic [6:0] C_BR   = 7'b0010100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [REG_AW-1:0] ID_Rs, ID_Rt, EXE_Rs, EXE_Rt, EXE_Rw, MEM_Rw, WB_Rw;
  logic ID_UseRt, EXE_UseRt, EXE_RegWr, EXE_MemtoReg, EXE_MulStart;
  logic Branch_Taken, MEM_RegWr, MEM_MemtoReg, WB_RegWr;
  logic [1:0] FwdA, FwdB;
  logic PC_Hold, IFID_Hold, IFID_Flush, IDEX_Hold, IDEX_Flush, EXMEM_Flush, Mul_Busy;
`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] Stall_Cycles;
`endif

  always #5 clk = ~clk;

  hazard_ctrl_unit #(
    .REG_AW   (REG_AW),
    .LOAD_LAT (LOAD_LAT),
    .MUL_LAT  (MUL_LAT)
`ifdef HAZ_STALL_CNT_EN
    , .CNT_W  (CNT_W)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ID_Rs        (ID_Rs),
    .ID_Rt        (ID_Rt),
    .ID_UseRt     (ID_UseRt),
    .EXE_Rs       (EXE_Rs),
    .EXE_Rt       (EXE_Rt),
    .EXE_UseRt    (EXE_UseRt),
    .EXE_Rw       (EXE_Rw),
    .EXE_RegWr    (EXE_RegWr),
    .EXE_MemtoReg (EXE_MemtoReg),
    .EXE_MulStart (EXE_MulStart),
    .Branch_Taken (Branch_Taken),
    .MEM_Rw       (MEM_Rw),
    .MEM_RegWr    (MEM_RegWr),
    .MEM_MemtoReg (MEM_MemtoReg),
    .WB_Rw        (WB_Rw),
    .WB_RegWr     (WB_RegWr),
    .FwdA         (FwdA),
    .FwdB         (FwdB),
    .PC_Hold      (PC_Hold),
    .IFID_Hold    (IFID_Hold),
    .IFID_Flush   (IFID_Flush),
    .IDEX_Hold    (IDEX_Hold),
    .IDEX_Flush   (IDEX_Flush),
    .EXMEM_Flush  (EXMEM_Flush),
    .Mul_Busy     (Mul_Busy)
`ifdef HAZ_STALL_CNT_EN
    , .Stall_Cycles (Stall_Cycles)
`endif
  );

  logic [6:0] ctl;
  assign ctl = {PC_Hold, IFID_Hold, IFID_Flush, IDEX_Hold, IDEX_Flush, EXMEM_Flush, Mul_Busy};

  int checks   = 0;
  int failures = 0;

  // Reference model state: remaining load-stall cycles, remaining multiply
  // busy cycles, and PC_Hold cycles seen so far.
  int m_ld   = 0;
  int m_mul  = 0;
  int m_scnt = 0;

  typedef struct {
    logic [REG_AW-1:0] exe_rs;
    logic [REG_AW-1:0] exe_rt;
    logic              use_rt;
    logic [REG_AW-1:0] mem_rw;
    logic              mem_wr;
    logic              mem_ld;
    logic [REG_AW-1:0] wb_rw;
    logic              wb_wr;
    logic [1:0]        exp_a;
    logic [1:0]        exp_b;
  } fwd_vec_t;

  fwd_vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ID_Rs = '0; ID_Rt = '0; ID_UseRt = 1'b0;
    EXE_Rs = '0; EXE_Rt = '0; EXE_UseRt = 1'b0;
    EXE_Rw = '0; EXE_RegWr = 1'b0; EXE_MemtoReg = 1'b0; EXE_MulStart = 1'b0;
    Branch_Taken = 1'b0;
    MEM_Rw = '0; MEM_RegWr = 1'b0; MEM_MemtoReg = 1'b0;
    WB_Rw = '0; WB_RegWr = 1'b0;
  endtask

  // Leaves the bench 1 time unit after a rising edge, reset released.
  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_ld = 0; m_mul = 0; m_scnt = 0;
  endtask

  task automatic set_load_use(input logic [REG_AW-1:0] r);
    EXE_MemtoReg = 1'b1; EXE_RegWr = 1'b1; EXE_Rw = r; ID_Rs = r;
  endtask

  task automatic clr_load_use();
    EXE_MemtoReg = 1'b0; EXE_RegWr = 1'b0; EXE_Rw = '0; ID_Rs = '0;
  endtask

  // One clock cycle with a check of the control vector mid-cycle.
  task automatic cyc(input string name, input logic [6:0] exp);
    @(negedge clk);
    chk(name, {25'd0, ctl}, {25'd0, exp});
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] fwd_model(input logic [REG_AW-1:0] src, input logic used);
    if (!used || src == '0) return 2'b10;
    if (MEM_RegWr && !MEM_MemtoReg && MEM_Rw == src) return 2'b00;
    if (WB_RegWr && WB_Rw == src) return 2'b01;
    return 2'b10;
  endfunction

  // One clock cycle checked against the reference model, then model advance.
  task automatic model_cycle();
    bit busy, luh, ld;
    logic [6:0] exp;
    @(negedge clk);
    busy = (m_mul > 0);
    luh  = EXE_MemtoReg && EXE_RegWr && (EXE_Rw != 0) &&
           (ID_Rs == EXE_Rw || (ID_UseRt && ID_Rt == EXE_Rw));
    ld   = (m_ld > 0) || luh;
    if (busy)              exp = C_MUL;
    else if (Branch_Taken) exp = C_BR;
    else if (ld)           exp = C_LD;
    else                   exp = C_NONE;
    chk("rnd_ctl",  {25'd0, ctl},  {25'd0, exp});
    chk("rnd_fwdA", {30'd0, FwdA}, {30'd0, fwd_model(EXE_Rs, 1'b1)});
    chk("rnd_fwdB", {30'd0, FwdB}, {30'd0, fwd_model(EXE_Rt, EXE_UseRt)});
`ifdef HAZ_STALL_CNT_EN
    chk("rnd_stall_cnt", {28'd0, Stall_Cycles}, m_scnt);
    if (exp[6] && m_scnt < (2**CNT_W - 1)) m_scnt++;
`endif
    if (busy) begin
      m_mul--;
    end else begin
      if (EXE_MulStart) m_mul = MUL_LAT - 1;
      if (Branch_Taken) m_ld = 0;
      else if (ld) begin
        if (m_ld == 0) m_ld = LOAD_LAT;
        m_ld--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 2'b00, 2'b10};
    vecs[1] = '{5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 2'b01, 2'b10};
    vecs[2] = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 2'b10, 2'b10};
    vecs[3] = '{5'd1, 5'd5, 1'b0, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 2'b10, 2'b10};
    vecs[4] = '{5'd1, 5'd5, 1'b1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 2'b10, 2'b01};
    vecs[5] = '{5'd7, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 2'b01, 2'b01};
    vecs[6] = '{5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b0, 2'b00, 2'b00};
    vecs[7] = '{5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 2'b10, 2'b10};

    // Reset state: outputs idle even with hazard/forward/branch inputs active.
    clear_inputs();
    set_load_use(5'd8);
    EXE_Rs = 5'd3; MEM_Rw = 5'd3; MEM_RegWr = 1'b1; Branch_Taken = 1'b1;
    #3;
    chk("reset_ctl",  {25'd0, ctl},  {25'd0, C_NONE});
    chk("reset_fwdA", {30'd0, FwdA}, 32'd2);
    chk("reset_fwdB", {30'd0, FwdB}, 32'd2);
    do_reset();
`ifdef HAZ_STALL_CNT_EN
    chk("stall_cnt_reset", {28'd0, Stall_Cycles}, 32'd0);
`endif
    cyc("idle_after_reset", C_NONE);

    // Forwarding table
    for (int i = 0; i < 8; i++) begin
      EXE_Rs = vecs[i].exe_rs; EXE_Rt = vecs[i].exe_rt; EXE_UseRt = vecs[i].use_rt;
      MEM_Rw = vecs[i].mem_rw; MEM_RegWr = vecs[i].mem_wr; MEM_MemtoReg = vecs[i].mem_ld;
      WB_Rw = vecs[i].wb_rw; WB_RegWr = vecs[i].wb_wr;
      @(negedge clk);
      chk($sformatf("fwdA_vec%0d", i), {30'd0, FwdA}, {30'd0, vecs[i].exp_a});
      chk($sformatf("fwdB_vec%0d", i), {30'd0, FwdB}, {30'd0, vecs[i].exp_b});
      @(posedge clk);
      #1;
    end
    clear_inputs();

    // Load-use: exactly LOAD_LAT stall cycles
    do_reset();
    set_load_use(5'd8);
    cyc("ld_c1", C_LD);
    clr_load_use();
    cyc("ld_c2", C_LD);
    cyc("ld_c3", C_LD);
    cyc("ld_end", C_NONE);
    EXE_MemtoReg = 1'b1; EXE_RegWr = 1'b1; EXE_Rw = '0; ID_Rs = '0;
    cyc("ld_rw0", C_NONE);
    clr_load_use();

    // Multiply: busy MUL_LAT-1 cycles, restart while busy ignored
    EXE_MulStart = 1'b1;
    cyc("mul_start", C_NONE);
    EXE_MulStart = 1'b0;
    cyc("mul_b1", C_MUL);
    EXE_MulStart = 1'b1;
    cyc("mul_b2", C_MUL);
    EXE_MulStart = 1'b0;
    cyc("mul_b3", C_MUL);
    cyc("mul_end", C_NONE);

    // Load stall interrupted by a multiply resumes with its remaining count
    set_load_use(5'd4);
    cyc("cc_ld1", C_LD);
    clr_load_use();
    EXE_MulStart = 1'b1;
    cyc("cc_ld2", C_LD);
    EXE_MulStart = 1'b0;
    cyc("cc_mul1", C_MUL);
    cyc("cc_mul2", C_MUL);
    cyc("cc_mul3", C_MUL);
    cyc("cc_ld3", C_LD);
    cyc("cc_done", C_NONE);

    // Branch taken in the first load-stall cycle cancels the stall
    set_load_use(5'd6);
    Branch_Taken = 1'b1;
    cyc("br_flush", C_BR);
    clr_load_use();
    Branch_Taken = 1'b0;
    cyc("br_after", C_NONE);

    // Async reset mid-stall
    do_reset();
    set_load_use(5'd8);
    cyc("rst_ld1", C_LD);
    clr_load_use();
    cyc("rst_ld2", C_LD);
    set_load_use(5'd8);
    EXE_Rs = 5'd3; MEM_Rw = 5'd3; MEM_RegWr = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl",  {25'd0, ctl},  {25'd0, C_NONE});
    chk("rst_mid_fwdA", {30'd0, FwdA}, 32'd2);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("rst_released", C_NONE);

`ifdef HAZ_STALL_CNT_EN
    // 20 back-to-back stall cycles saturate a 4-bit counter
    do_reset();
    set_load_use(5'd2);
    for (int i = 0; i < 20; i++) begin
      cyc("sat_stall", C_LD);
    end
    clr_load_use();
    @(negedge clk);
    chk("stall_cnt_sat", {28'd0, Stall_Cycles}, 32'd15);
    @(posedge clk);
    #1;
`endif

    // Randomized stimulus against the reference model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      ID_Rs        = REG_AW'($urandom_range(3, 0));
      ID_Rt        = REG_AW'($urandom_range(3, 0));
      ID_UseRt     = 1'($urandom_range(1, 0));
      EXE_Rs       = REG_AW'($urandom_range(3, 0));
      EXE_Rt       = REG_AW'($urandom_range(3, 0));
      EXE_UseRt    = 1'($urandom_range(1, 0));
      EXE_Rw       = REG_AW'($urandom_range(3, 0));
      EXE_RegWr    = 1'($urandom_range(1, 0));
      EXE_MemtoReg = ($urandom_range(2, 0) == 0);
      EXE_MulStart = ($urandom_range(9, 0) == 0);
      Branch_Taken = (m_mul == 0) && ($urandom_range(7, 0) == 0);
      MEM_Rw       = REG_AW'($urandom_range(3, 0));
      MEM_RegWr    = 1'($urandom_range(1, 0));
      MEM_MemtoReg = 1'($urandom_range(1, 0));
      WB_Rw        = REG_AW'($urandom_range(3, 0));
      WB_RegWr     = 1'($urandom_range(1, 0));
      model_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
